// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clrState_t;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    // A write or reserve aimed at a hard-wired zero register is discarded.
    function automatic logic isDropped(input int zeroReg, input logic idxIsZero);
        return (zeroReg != 0) && idxIsZero;
    endfunction

endpackage

// File: rtl/reg_file_sb_read_port.sv
// One read port: index mux, zero-register forcing, optional write-first bypass (REGFILE_BYPASS_EN).
// Latency: combinational, zero cycles.
// Backpressure: none; the port always returns a value.
module reg_file_sb_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
)(
    input  logic [AW-1:0]                 rs,
    input  logic [NREGS-1:0][XLEN-1:0]    regs,
    input  logic [NREGS-1:0]              busy,
    input  logic                          writeAcc,
    input  logic [AW-1:0]                 rd,
    input  logic [XLEN-1:0]               writeData,
    input  logic                          resAcc,
    input  logic [AW-1:0]                 reserveRd,
    output logic [XLEN-1:0]               readData,
    output logic                          busyOut
);

`ifndef REGFILE_BYPASS_EN
    // Write-side signals only matter when forwarding is built in.
    logic unusedBypass;
    assign unusedBypass = ^{writeAcc, rd, writeData, resAcc, reserveRd};
`endif

    // Select stored contents, optionally forward the accepted write, then force register 0.
    always_comb begin
        readData = regs[rs];
        busyOut  = busy[rs];
`ifdef REGFILE_BYPASS_EN
        if (writeAcc && (rd == rs)) begin
            readData = writeData;
            busyOut  = resAcc && (reserveRd == rs);
        end
`endif
        if (isDropped(ZERO_REG, rs == '0)) begin
            readData = '0;
            busyOut  = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard and sequenced bulk clear; optional read bypass via REGFILE_BYPASS_EN.
// Latency: reads combinational; writes/reserves visible next cycle; bulk clear takes NREGS cycles.
// Backpressure: none; writes, reserves and clear requests arriving during a clear are dropped.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEFAULT,
    parameter  int NREGS    = NREGS_DEFAULT,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] readData1,
    output logic [XLEN-1:0] readData2,
    output logic            busy1,
    output logic            busy2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] writeData,
    input  logic            regWrite,
    input  logic            reserveEn,
    input  logic [AW-1:0]   reserveRd,
    input  logic            clearReq,
    output logic            clearBusy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    clrState_t                  state;
    clrState_t                  nextState;
    logic [AW-1:0]              counter;
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic                       writeAcc;
    logic                       resAcc;

    // Reset gates acceptance so the bypass never forwards a write that will not land.
    assign writeAcc = rst && regWrite  && (state == IDLE) && !isDropped(ZERO_REG, rd == '0);
    assign resAcc   = rst && reserveEn && (state == IDLE) && !isDropped(ZERO_REG, reserveRd == '0);

    // Clear sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Clear sequencer next-state: leave CLEAR once the last register is being zeroed.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (clearReq)           nextState = CLEAR;
            CLEAR:   if (counter == LAST_IDX) nextState = IDLE;
            default:                          nextState = IDLE;
        endcase
    end

    // Clear index walks 0..NREGS-1 while clearing and parks at 0 otherwise.
    always_ff @(posedge clk) begin
        if (!rst)                  counter <= '0;
        else if (state == IDLE)    counter <= '0;
        else if (counter == LAST_IDX) counter <= '0;
        else                       counter <= counter + 1'b1;
    end

    // Register and scoreboard update; a clear request wipes busy on the same edge it is taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs <= '0;
            busy <= '0;
        end else if (state == CLEAR) begin
            regs[counter] <= '0;
        end else begin
            if (writeAcc) begin
                regs[rd] <= writeData;
                busy[rd] <= 1'b0;
            end
            if (resAcc)   busy[reserveRd] <= 1'b1;
            if (clearReq) busy <= '0;
        end
    end

    assign clearBusy = (state == CLEAR);

    reg_file_sb_read_port #(
        .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .AW(AW)
    ) uPort1 (
        .rs(rs1), .regs(regs), .busy(busy),
        .writeAcc(writeAcc), .rd(rd), .writeData(writeData),
        .resAcc(resAcc), .reserveRd(reserveRd),
        .readData(readData1), .busyOut(busy1)
    );

    reg_file_sb_read_port #(
        .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .AW(AW)
    ) uPort2 (
        .rs(rs2), .regs(regs), .busy(busy),
        .writeAcc(writeAcc), .rd(rd), .writeData(writeData),
        .resAcc(resAcc), .reserveRd(reserveRd),
        .readData(readData2), .busyOut(busy2)
    );

endmodule
